// File: rtl/gsm_bus_sched.sv
// Common-bus slot scheduler: 4:1 TDM one-hot select locked to an 80MHz frame-sync pulse.
// Optional feature: define GSM_SCHED_SKIP_IDLE_EN to blank slots whose port has no pending request.
module gsm_bus_sched #(
    parameter int MWIDTH     = 4,
    parameter int LOG_MWIDTH = 2,
    parameter int LOCK_CNT   = 2
) (
    input  logic                  clk_320M,
    input  logic                  rst_n,
    input  logic                  clr_320M,
    input  logic                  i_frame_sync,
    input  logic [MWIDTH-1:0]     i_port_en,
    input  logic [MWIDTH-1:0]     i_req,
    output logic [MWIDTH-1:0]     o_common_sel,
    output logic [LOG_MWIDTH-1:0] o_slot_idx,
    output logic                  o_locked,
    output logic                  o_sync_err
);

    // state | meaning
    // HUNT  | waiting for any frame-sync pulse
    // ALIGN | counting correctly spaced syncs toward lock
    // RUN   | locked, issuing one slot per port per frame
    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] ALIGN = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    localparam logic [LOG_MWIDTH-1:0] LAST_PHASE = LOG_MWIDTH'(MWIDTH - 1);
    localparam logic [2:0]            LOCK_TGT   = 3'(LOCK_CNT);

    logic [1:0]            state_q, state_d;
    logic [LOG_MWIDTH-1:0] phase_q, phase_d;
    logic [2:0]            lock_q, lock_d;
    logic [MWIDTH-1:0]     en_q, en_d;
    logic                  err_d;
    logic                  frame_start;
    logic                  at_last;
    logic [MWIDTH-1:0]     req_gate;
    logic [MWIDTH-1:0]     sel_d;
    logic [LOG_MWIDTH-1:0] idx_d;

    assign at_last = (phase_q == LAST_PHASE);

`ifdef GSM_SCHED_SKIP_IDLE_EN
    // Request sampled in the cycle before the slot, registered together with the select.
    assign req_gate = i_req;
`else
    logic unused_req;
    assign unused_req = ^i_req;
    assign req_gate   = '1;
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + 1'b1;
        lock_d      = lock_q;
        en_d        = en_q;
        err_d       = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            HUNT: begin
                phase_d = '0;
                if (i_frame_sync) begin
                    lock_d = 3'd1;
                    if (LOCK_CNT == 1) begin
                        state_d     = RUN;
                        frame_start = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (i_frame_sync) begin
                    if (at_last) begin
                        if (lock_q + 3'd1 >= LOCK_TGT) begin
                            state_d     = RUN;
                            frame_start = 1'b1;
                        end
                        lock_d = lock_q + 3'd1;
                    end else begin
                        // misplaced sync restarts alignment on itself
                        lock_d  = 3'd1;
                        phase_d = '0;
                    end
                end else if (at_last) begin
                    state_d = HUNT;
                    lock_d  = '0;
                    phase_d = '0;
                end
            end
            RUN: begin
                if (i_frame_sync != at_last) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                    lock_d  = '0;
                    phase_d = '0;
                end else if (i_frame_sync) begin
                    frame_start = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
                lock_d  = '0;
                phase_d = '0;
            end
        endcase
        if (frame_start) en_d = i_port_en;
    end

    always_comb begin
        sel_d = '0;
        idx_d = '0;
        if (state_d == RUN) begin
            sel_d = (MWIDTH'(1) << phase_d) & en_d & req_gate;
            idx_d = phase_d;
        end
    end

    always_ff @(posedge clk_320M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            phase_q      <= '0;
            lock_q       <= '0;
            en_q         <= '0;
            o_common_sel <= '0;
            o_slot_idx   <= '0;
            o_locked     <= 1'b0;
            o_sync_err   <= 1'b0;
        end else if (clr_320M) begin
            state_q      <= HUNT;
            phase_q      <= '0;
            lock_q       <= '0;
            en_q         <= '0;
            o_common_sel <= '0;
            o_slot_idx   <= '0;
            o_locked     <= 1'b0;
            o_sync_err   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            lock_q       <= lock_d;
            en_q         <= en_d;
            o_common_sel <= sel_d;
            o_slot_idx   <= idx_d;
            o_locked     <= (state_d == RUN);
            o_sync_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_gsm_bus_sched.sv
// Directed vector bench for gsm_bus_sched (default LOCK_CNT=2, MWIDTH=4).
`timescale 1ns/1ps
module tb_gsm_bus_sched;

    typedef struct {
        logic       sync;
        logic [3:0] en;
        logic [3:0] req;
        logic       clr;
        logic [3:0] sel;
        logic [1:0] idx;
        logic       lk;
        logic       err;
    } vec_t;

    logic       clk_320M = 1'b0;
    logic       rst_n;
    logic       clr_320M;
    logic       i_frame_sync;
    logic [3:0] i_port_en;
    logic [3:0] i_req;
    logic [3:0] o_common_sel;
    logic [1:0] o_slot_idx;
    logic       o_locked;
    logic       o_sync_err;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vq[$];

    gsm_bus_sched dut (
        .clk_320M     (clk_320M),
        .rst_n        (rst_n),
        .clr_320M     (clr_320M),
        .i_frame_sync (i_frame_sync),
        .i_port_en    (i_port_en),
        .i_req        (i_req),
        .o_common_sel (o_common_sel),
        .o_slot_idx   (o_slot_idx),
        .o_locked     (o_locked),
        .o_sync_err   (o_sync_err)
    );

    always #2 clk_320M = ~clk_320M;

    task automatic add(input logic s, input logic [3:0] en, input logic [3:0] req, input logic c,
                       input logic [3:0] sel, input logic [1:0] idx, input logic lk, input logic err);
        vec_t v;
        v.sync = s; v.en = en; v.req = req; v.clr = c;
        v.sel = sel; v.idx = idx; v.lk = lk; v.err = err;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input vec_t v);
        n_vec++;
        if (o_common_sel !== v.sel || o_slot_idx !== v.idx || o_locked !== v.lk ||
            o_sync_err !== v.err || !$onehot0(o_common_sel)) begin
            n_bad++;
            $display("FAIL %s: got sel=%b idx=%0d lk=%b err=%b, want sel=%b idx=%0d lk=%b err=%b",
                     name, o_common_sel, o_slot_idx, o_locked, o_sync_err,
                     v.sel, v.idx, v.lk, v.err);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clk_320M);
        i_frame_sync = v.sync;
        i_port_en    = v.en;
        i_req        = v.req;
        clr_320M     = v.clr;
        @(posedge clk_320M);
        #1;
        check(name, v);
    endtask

    localparam logic [3:0] F = 4'hF;
    localparam logic [3:0] B = 4'b1011;
    localparam logic [3:0] R = 4'b0101;
`ifdef GSM_SCHED_SKIP_IDLE_EN
    localparam logic [3:0] S1 = 4'b0000;
    localparam logic [3:0] S3 = 4'b0000;
`else
    localparam logic [3:0] S1 = 4'b0010;
    localparam logic [3:0] S3 = 4'b1000;
`endif

    initial begin
        vec_t z;
        z.sync = 0; z.en = F; z.req = F; z.clr = 0;
        z.sel = 0; z.idx = 0; z.lk = 0; z.err = 0;

        //   sync en req clr   sel      idx  lk err
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(1, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(1, F, F, 0, 4'b0001, 0, 1, 0);   // second sync: lock
        add(0, F, F, 0, 4'b0010, 1, 1, 0);
        add(0, F, F, 0, 4'b0100, 2, 1, 0);
        add(0, F, F, 0, 4'b1000, 3, 1, 0);
        add(1, F, F, 0, 4'b0001, 0, 1, 0);
        add(0, B, F, 0, 4'b0010, 1, 1, 0);   // enables change mid-frame
        add(0, B, F, 0, 4'b0100, 2, 1, 0);
        add(0, B, F, 0, 4'b1000, 3, 1, 0);
        add(1, B, F, 0, 4'b0001, 0, 1, 0);
        add(0, B, F, 0, 4'b0010, 1, 1, 0);
        add(0, B, F, 0, 4'b0000, 2, 1, 0);
        add(0, B, F, 0, 4'b1000, 3, 1, 0);
        add(1, B, F, 0, 4'b0001, 0, 1, 0);
        add(0, B, F, 0, 4'b0010, 1, 1, 0);
        add(1, B, F, 0, 4'b0000, 0, 0, 1);   // misplaced sync in RUN
        add(0, B, F, 0, 4'b0000, 0, 0, 0);
        add(1, B, F, 0, 4'b0000, 0, 0, 0);
        add(0, B, F, 0, 4'b0000, 0, 0, 0);
        add(0, B, F, 0, 4'b0000, 0, 0, 0);
        add(0, B, F, 0, 4'b0000, 0, 0, 0);
        add(1, B, F, 0, 4'b0001, 0, 1, 0);
        add(0, B, F, 0, 4'b0010, 1, 1, 0);
        add(0, B, F, 0, 4'b0000, 2, 1, 0);
        add(0, B, F, 0, 4'b1000, 3, 1, 0);
        add(0, B, F, 0, 4'b0000, 0, 0, 1);   // missing sync in RUN
        add(0, B, F, 0, 4'b0000, 0, 0, 0);
        add(1, B, F, 0, 4'b0000, 0, 0, 0);
        add(0, B, F, 0, 4'b0000, 0, 0, 0);
        add(1, B, F, 0, 4'b0000, 0, 0, 0);   // misplaced sync in ALIGN restarts, no err
        add(0, B, F, 0, 4'b0000, 0, 0, 0);
        add(0, B, F, 0, 4'b0000, 0, 0, 0);
        add(0, B, F, 0, 4'b0000, 0, 0, 0);
        add(1, B, F, 0, 4'b0001, 0, 1, 0);
        add(0, F, F, 0, 4'b0010, 1, 1, 0);
        add(0, F, F, 0, 4'b0000, 2, 1, 0);
        add(0, F, F, 0, 4'b1000, 3, 1, 0);
        add(1, F, F, 0, 4'b0001, 0, 1, 0);
        add(0, F, F, 0, 4'b0010, 1, 1, 0);
        add(0, F, F, 0, 4'b0100, 2, 1, 0);
        add(0, F, F, 0, 4'b1000, 3, 1, 0);
        add(1, F, F, 1, 4'b0000, 0, 0, 0);   // clear wins over good sync
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(1, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);   // missing sync in ALIGN -> HUNT
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(1, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(0, F, F, 0, 4'b0000, 0, 0, 0);
        add(1, F, F, 0, 4'b0001, 0, 1, 0);
        add(0, F, R, 0, S1,      1, 1, 0);   // request pattern 0101
        add(0, F, R, 0, 4'b0100, 2, 1, 0);
        add(0, F, R, 0, S3,      3, 1, 0);
        add(1, F, R, 0, 4'b0001, 0, 1, 0);

        rst_n = 1'b0; clr_320M = 1'b0; i_frame_sync = 1'b0; i_port_en = F; i_req = F;
        repeat (3) @(posedge clk_320M);
        #1;
        check("reset_state", z);
        @(negedge clk_320M);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++)
            apply($sformatf("vec%0d", i), vq[i]);

        // async reset while in RUN
        @(negedge clk_320M);
        rst_n = 1'b0; i_frame_sync = 1'b0;
        #1;
        check("async_rst_now", z);
        @(posedge clk_320M);
        #1;
        check("async_rst_next", z);
        @(negedge clk_320M);
        rst_n = 1'b1;
        begin
            vec_t v;
            v = z; v.sync = 1;
            apply("rst_sync1", v);
            v = z;
            apply("rst_idle1", v);
            apply("rst_idle2", v);
            apply("rst_idle3", v);
            v = z; v.sync = 1; v.sel = 4'b0001; v.lk = 1;
            apply("rst_sync2", v);
            v = z; v.sync = 1; v.clr = 1;
            apply("clr_misplaced", v);
            v = z;
            apply("clr_after", v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
